phy_regfile2rs_dispatch_q: RTL

//  Parametrised dispatch queue between the physical regfile read stage and the reservation stations.

---
 rtl/phy_regfile2rs_dispatch_q.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/phy_regfile2rs_dispatch_q.sv
// phy_regfile2rs_dispatch_q: dispatch queue from regfile read to reservation stations with CDB wakeup
// Ports:
//   clk, reset (sync, active-high), flush   : clock, reset, discard all entries
//   in_valid/in_ready, in_*                 : producer side, one renamed instruction per cycle
//   cdb_valid/cdb_tag/cdb_val               : CDB_PORTS broadcast ports, port k at [k*W +: W]
//   out_valid/out_ready, out_*              : head entry toward the RS, data zeroed when empty
//   count                                   : occupancy
module phy_regfile2rs_dispatch_q #(
    parameter int DEPTH     = 4,
    parameter int VAL_W     = 32,
    parameter int PREG_W    = 6,
    parameter int PC_W      = 32,
    parameter int CTRL_W    = 8,
    parameter int CDB_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CTRL_W-1:0]             in_control,
    input  logic [VAL_W-1:0]              in_src1_val,
    input  logic [VAL_W-1:0]              in_src2_val,
    input  logic                          in_src1_rdy,
    input  logic                          in_src2_rdy,
    input  logic [PREG_W-1:0]             in_src1_addr,
    input  logic [PREG_W-1:0]             in_src2_addr,
    input  logic [PREG_W-1:0]             in_dst_addr,
    input  logic [VAL_W-1:0]              in_immediate,
    input  logic [PC_W-1:0]               in_pc,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*PREG_W-1:0]   cdb_tag,
    input  logic [CDB_PORTS*VAL_W-1:0]    cdb_val,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CTRL_W-1:0]             out_control,
    output logic [VAL_W-1:0]              out_src1_val,
    output logic [VAL_W-1:0]              out_src2_val,
    output logic                          out_src1_rdy,
    output logic                          out_src2_rdy,
    output logic [PREG_W-1:0]             out_src1_addr,
    output logic [PREG_W-1:0]             out_src2_addr,
    output logic [PREG_W-1:0]             out_dst_addr,
    output logic [VAL_W-1:0]              out_immediate,
    output logic [PC_W-1:0]               out_pc,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int AW = $clog2(DEPTH);

    logic [CTRL_W-1:0] ctrl_m [DEPTH];
    logic [VAL_W-1:0]  v1_m   [DEPTH];
    logic [VAL_W-1:0]  v2_m   [DEPTH];
    logic              r1_m   [DEPTH];
    logic              r2_m   [DEPTH];
    logic [PREG_W-1:0] a1_m   [DEPTH];
    logic [PREG_W-1:0] a2_m   [DEPTH];
    logic [PREG_W-1:0] dst_m  [DEPTH];
    logic [VAL_W-1:0]  imm_m  [DEPTH];
    logic [PC_W-1:0]   pc_m   [DEPTH];

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          enq, deq;
    logic [VAL_W:0] s1 [DEPTH];
    logic [VAL_W:0] s2 [DEPTH];
    logic [VAL_W:0] in_s1, in_s2;

    // Returns {hit, value}; scanning from the top port down lets the lowest matching port win.
    function automatic logic [VAL_W:0] snoop(
        input logic [PREG_W-1:0]           tag,
        input logic [CDB_PORTS-1:0]        v,
        input logic [CDB_PORTS*PREG_W-1:0] t,
        input logic [CDB_PORTS*VAL_W-1:0]  d
    );
        snoop = '0;
        for (int k = CDB_PORTS - 1; k >= 0; k--)
            if (v[k] && t[k*PREG_W +: PREG_W] == tag) snoop = {1'b1, d[k*VAL_W +: VAL_W]};
    endfunction

    assign in_ready  = count != (AW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            s1[i] = snoop(a1_m[i], cdb_valid, cdb_tag, cdb_val);
            s2[i] = snoop(a2_m[i], cdb_valid, cdb_tag, cdb_val);
        end
        in_s1 = snoop(in_src1_addr, cdb_valid, cdb_tag, cdb_val);
        in_s2 = snoop(in_src2_addr, cdb_valid, cdb_tag, cdb_val);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(deq);
            wr_ptr <= wr_ptr + AW'(enq);
            count  <= count + (AW+1)'(enq) - (AW+1)'(deq);
        end
    end

    // Storage is never cleared; stale slots are unobservable once the pointers reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && wr_ptr == AW'(i)) begin
                ctrl_m[i] <= in_control;
                a1_m[i]   <= in_src1_addr;
                a2_m[i]   <= in_src2_addr;
                dst_m[i]  <= in_dst_addr;
                imm_m[i]  <= in_immediate;
                pc_m[i]   <= in_pc;
                r1_m[i]   <= in_src1_rdy || in_s1[VAL_W];
                r2_m[i]   <= in_src2_rdy || in_s2[VAL_W];
                v1_m[i]   <= (!in_src1_rdy && in_s1[VAL_W]) ? in_s1[VAL_W-1:0] : in_src1_val;
                v2_m[i]   <= (!in_src2_rdy && in_s2[VAL_W]) ? in_s2[VAL_W-1:0] : in_src2_val;
            end else begin
                if (!r1_m[i] && s1[i][VAL_W]) begin
                    r1_m[i] <= 1'b1;
                    v1_m[i] <= s1[i][VAL_W-1:0];
                end
                if (!r2_m[i] && s2[i][VAL_W]) begin
                    r2_m[i] <= 1'b1;
                    v2_m[i] <= s2[i][VAL_W-1:0];
                end
            end
        end
    end

    // Head bypass: a same-cycle CDB match is visible at the output so a leaving head keeps its wakeup.
    always_comb begin
        out_control   = out_valid ? ctrl_m[rd_ptr] : '0;
        out_src1_addr = out_valid ? a1_m[rd_ptr] : '0;
        out_src2_addr = out_valid ? a2_m[rd_ptr] : '0;
        out_dst_addr  = out_valid ? dst_m[rd_ptr] : '0;
        out_immediate = out_valid ? imm_m[rd_ptr] : '0;
        out_pc        = out_valid ? pc_m[rd_ptr] : '0;
        out_src1_rdy  = out_valid && (r1_m[rd_ptr] || s1[rd_ptr][VAL_W]);
        out_src2_rdy  = out_valid && (r2_m[rd_ptr] || s2[rd_ptr][VAL_W]);
        out_src1_val  = !out_valid ? '0 : (!r1_m[rd_ptr] && s1[rd_ptr][VAL_W]) ? s1[rd_ptr][VAL_W-1:0] : v1_m[rd_ptr];
        out_src2_val  = !out_valid ? '0 : (!r2_m[rd_ptr] && s2[rd_ptr][VAL_W]) ? s2[rd_ptr][VAL_W-1:0] : v2_m[rd_ptr];
    end
endmodule
